seq_mac_unit: RTL and testbench
===============================

SEQ_MAC_UNIT -- requirements
Module: seq_mac_unit

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits (legal range 2..16).
REQ-002 SHALL have parameter ACC_W, default 16, result/accumulator width in bits (legal when ACC_W >= 2*W).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port mode  input  2  operation: 00 add, 01 multiply, 10 multiply-accumulate, 11 reserved.
REQ-007 SHALL have port A  input  W  unsigned operand A.
REQ-008 SHALL have port B  input  W  unsigned operand B.
REQ-009 SHALL have port clear  input  1  synchronous accumulator clear, honoured only in IDLE.
REQ-010 SHALL have port C  output  ACC_W  result/accumulator register.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port erroren  output  1  one-cycle error pulse, coincident with done.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE, ERR; EXEC, DONE and ERR return only as listed below.
REQ-015 IDLE with start=1 and mode!=11 SHALL capture A, B, mode into internal registers, load cycle counter to 0, go to EXEC.
REQ-016 IDLE with start=1 and mode=11 SHALL go to ERR without modifying C.
REQ-017 IDLE with start=0 and clear=1 SHALL set C to 0 at the next edge; clear with start=1 SHALL be ignored (start wins, no clear).
REQ-018 Inputs A, B, mode, start, clear SHALL be ignored outside IDLE; operand changes during EXEC SHALL not affect the result.
REQ-019 Add (00): EXEC SHALL last exactly 1 cycle; result = zero-extended A + B.
REQ-020 Multiply (01) and MAC (10): EXEC SHALL last exactly W cycles, shift-add: each cycle, if current LSB of shifted B is 1, add A shifted left by counter to a 2W-bit partial product; counter increments 0..W-1.
REQ-021 Multiply result = 2W-bit product zero-extended to ACC_W; add and multiply SHALL overwrite C.
REQ-022 MAC result = C + product computed at ACC_W+1 bits; if bit ACC_W is set, C SHALL saturate to all ones and the op SHALL go to ERR instead of DONE.
REQ-023 On leaving the last EXEC cycle C SHALL be updated at the same edge as the transition into DONE (or ERR on saturation).
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-025 ERR SHALL assert done=1 and erroren=1 for exactly one cycle, then return to IDLE.
REQ-026 Latency from the edge sampling start to done high: add 2 cycles, multiply/MAC W+1 cycles, reserved mode 1 cycle.
REQ-027 start held high continuously SHALL launch a new op on the first IDLE cycle after each DONE/ERR (back-to-back, one IDLE cycle between ops).
REQ-028 C SHALL hold its value between operations; no output SHALL be driven by combinational paths from inputs.

Reset
REQ-029 reset=1 SHALL immediately, independent of clk, force state IDLE, C=0, done=0, busy=0, erroren=0, counter and captured operands 0.
REQ-030 Reset asserted mid-EXEC SHALL abort the op with no done pulse; the first op after reset release SHALL behave as from power-up.

Verification (W=4, ACC_W=16 unless noted)
REQ-031 Add: A=5, B=3, mode=00, start one cycle -> done high 2 cycles later, C=8, erroren=0, busy high 2 cycles.
REQ-032 Multiply: A=15, B=15, mode=01 -> done after 5 cycles, C=225; then A=0, B=9 -> C=0.
REQ-033 MAC with clear: clear, then three MACs A=7,B=6 -> C=42, 84, 126; clear -> C=0.
REQ-034 Saturation (ACC_W=8): MAC 15*15 twice -> first C=225 done/erroren=0, second C=255 with done=1, erroren=1.
REQ-035 Reserved mode: mode=11 with C=42 -> done and erroren high 1 cycle after start, C stays 42, busy high 1 cycle.
REQ-036 Reset mid-multiply: assert reset in 2nd EXEC cycle -> outputs 0 immediately, no done; after release, A=3,B=4 mode=01 -> C=12.

Source files
------------

// File: rtl/seq_mac_unit.sv
// Sequential multiply/accumulate unit: single-cycle add, W-cycle shift-add multiply,
// and saturating multiply-accumulate into the C register, controlled by a small FSM.
module seq_mac_unit #(
  parameter int W     = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             clear,
  output logic [ACC_W-1:0] C,
  output logic             done,
  output logic             busy,
  output logic             erroren
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, ERR} state_t;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_MUL = 2'b01;
  localparam logic [1:0] MODE_RSV = 2'b11;
  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t             state, state_nx;
  logic [W-1:0]       a_r, b_sh;
  logic [1:0]         mode_r;
  logic [CNT_W-1:0]   cnt;
  logic [2*W-1:0]     pp, pp_nx, addend;
  logic [ACC_W-1:0]   c_nx;
  logic [ACC_W:0]     mac_r;

  // Top bit of the result flags overflow; the low ACC_W bits are the clamped sum.
  function automatic logic [ACC_W:0] sat_acc(input logic [ACC_W-1:0] acc,
                                             input logic [2*W-1:0]   prod);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + (ACC_W+1)'(prod);
    if (sum[ACC_W]) sat_acc = {1'b1, {ACC_W{1'b1}}};
    else            sat_acc = sum;
  endfunction

  always_comb begin
    addend   = b_sh[0] ? ({{W{1'b0}}, a_r} << cnt) : '0;
    pp_nx    = pp + addend;
    state_nx = state;
    c_nx     = C;
    mac_r    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (mode == MODE_RSV) ? ERR : EXEC;
        end else if (clear) begin
          c_nx = '0;
        end
      end
      EXEC: begin
        if (mode_r == MODE_ADD) begin
          c_nx     = ACC_W'(a_r) + ACC_W'(b_sh);
          state_nx = DONE;
        end else if (cnt == CNT_LAST) begin
          // The final partial product is folded in combinationally so C lands with DONE.
          if (mode_r == MODE_MUL) begin
            c_nx     = ACC_W'(pp_nx);
            state_nx = DONE;
          end else begin
            mac_r    = sat_acc(C, pp_nx);
            c_nx     = mac_r[ACC_W-1:0];
            state_nx = mac_r[ACC_W] ? ERR : DONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_r     <= '0;
      b_sh    <= '0;
      mode_r  <= '0;
      cnt     <= '0;
      pp      <= '0;
      C       <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      erroren <= 1'b0;
    end else begin
      state   <= state_nx;
      C       <= c_nx;
      done    <= (state_nx == DONE) || (state_nx == ERR);
      erroren <= (state_nx == ERR);
      busy    <= (state_nx != IDLE);
      if (state == IDLE && start && mode != MODE_RSV) begin
        a_r    <= A;
        b_sh   <= B;
        mode_r <= mode;
        cnt    <= '0;
        pp     <= '0;
      end else if (state == EXEC) begin
        b_sh <= b_sh >> 1;
        cnt  <= cnt + 1'b1;
        pp   <= pp_nx;
      end
    end
  end

endmodule

// File: tb/tb_seq_mac_unit.sv
// Scoreboard bench for seq_mac_unit: a 16-bit accumulator instance and an 8-bit one
// for saturation, with monitors popping expected results on every done pulse.
module tb_seq_mac_unit;
  localparam int W = 4;

  logic          clk = 1'b0, reset = 1'b0, clear = 1'b0;
  logic          start16 = 1'b0, start8 = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  A = '0, B = '0;
  logic [15:0]   c16;
  logic [7:0]    c8;
  logic          done16, busy16, err16, done8, busy8, err8;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [15:0] c;
    logic        err;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  exp_t m16, m8;

  always #5 clk = ~clk;

  seq_mac_unit #(.W(W), .ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .mode(mode), .A(A), .B(B),
    .clear(clear), .C(c16), .done(done16), .busy(busy16), .erroren(err16)
  );

  seq_mac_unit #(.W(W), .ACC_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode), .A(A), .B(B),
    .clear(clear), .C(c8), .done(done8), .busy(busy8), .erroren(err8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) check("dut16 unexpected done", 1, 0);
      else begin
        m16 = q16.pop_front();
        check("dut16 C", {16'd0, c16}, {16'd0, m16.c});
        check("dut16 erroren", {31'd0, err16}, {31'd0, m16.err});
      end
    end else if (err16) check("dut16 erroren without done", 1, 0);
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check("dut8 unexpected done", 1, 0);
      else begin
        m8 = q8.pop_front();
        check("dut8 C", {24'd0, c8}, {16'd0, m8.c});
        check("dut8 erroren", {31'd0, err8}, {31'd0, m8.err});
      end
    end else if (err8) check("dut8 erroren without done", 1, 0);
  end

  // Issue one op, scramble operands after the start edge, and measure latency and busy.
  task automatic run_op(input bit sel, input logic [1:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [15:0] exp_c,
                        input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat, bcnt;
    logic d, bz;
    e.c = exp_c;
    e.err = exp_err;
    lat = 0;
    bcnt = 0;
    @(posedge clk); #1;
    mode = m; A = a; B = b;
    if (sel) begin start8 = 1'b1; q8.push_back(e); end
    else begin start16 = 1'b1; q16.push_back(e); end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    A = ~a; B = ~b; mode = ~m;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      d  = sel ? done8 : done16;
      bz = sel ? busy8 : busy16;
      if (bz) bcnt++;
      if (d) begin lat = i; break; end
    end
    if (lat == 0) check("done timeout", 0, 1);
    else begin
      check("latency", lat, exp_lat);
      check("busy cycles", bcnt, exp_lat);
    end
    @(posedge clk); #1;
    bz = sel ? busy8 : busy16;
    check("busy low after op", {31'd0, bz}, 0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear C", {16'd0, c16}, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset C", {16'd0, c16}, 0);
    check("reset done", {31'd0, done16}, 0);
    check("reset busy", {31'd0, busy16}, 0);
    check("reset erroren", {31'd0, err16}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(0, 2'b00, 4'd5, 4'd3, 16'd8, 1'b0, 2);
    run_op(0, 2'b01, 4'd15, 4'd15, 16'd225, 1'b0, 5);
    run_op(0, 2'b01, 4'd0, 4'd9, 16'd0, 1'b0, 5);

    do_clear();
    run_op(0, 2'b10, 4'd7, 4'd6, 16'd42, 1'b0, 5);
    run_op(0, 2'b10, 4'd7, 4'd6, 16'd84, 1'b0, 5);
    run_op(0, 2'b10, 4'd7, 4'd6, 16'd126, 1'b0, 5);
    do_clear();

    run_op(0, 2'b10, 4'd7, 4'd6, 16'd42, 1'b0, 5);
    run_op(0, 2'b11, 4'd1, 4'd1, 16'd42, 1'b1, 1);
    check("reserved keeps C", {16'd0, c16}, 42);

    run_op(1, 2'b10, 4'd15, 4'd15, 16'd225, 1'b0, 5);
    run_op(1, 2'b10, 4'd15, 4'd15, 16'd255, 1'b1, 5);

    // Abort a multiply in its second EXEC cycle.
    @(posedge clk); #1;
    mode = 2'b01; A = 4'd15; B = 4'd15; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid-op reset C", {16'd0, c16}, 0);
    check("mid-op reset busy", {31'd0, busy16}, 0);
    check("mid-op reset done", {31'd0, done16}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    run_op(0, 2'b01, 4'd3, 4'd4, 16'd12, 1'b0, 5);

    repeat (4) @(posedge clk);
    #1;
    check("dut16 pending results", q16.size(), 0);
    check("dut8 pending results", q8.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
